// File: rtl/tick_seq_pkg.sv
// Shared types for the tick sequencer: FSM states, error-cause codes and an index-width helper.
package tick_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } tick_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_CORE     = 2'b01;
  localparam logic [1:0] CAUSE_WATCHDOG = 2'b10;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_sequencer_lowest_set_index.sv
// Priority encoder: index of the lowest set bit of vec_i, with a valid flag.
module lowest_set_index
  import tick_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            vec_i,
  output logic [idx_width(WIDTH)-1:0] idx_o,
  output logic                        valid_o
);

  localparam int IDX_W = idx_width(WIDTH);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = {IDX_W{1'b0}};
    valid_o = |vec_i;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Global tick pacer for a neuromorphic core grid: issues a tick, waits for busy to fall and
// routers to settle, then issues the next. Optional watchdog built with TICK_SEQ_WATCHDOG_EN.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int NUM_CORES        = 4,
  parameter int TICK_COUNT_WIDTH = 16,
  parameter int MIN_TICK_PERIOD  = 300,
  parameter int SETTLE_CYCLES    = 4,
  parameter int WATCHDOG_CYCLES  = 65536
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [TICK_COUNT_WIDTH-1:0]         num_ticks,
  input  logic                                stop,
  input  logic [NUM_CORES-1:0]                core_busy,
  input  logic [NUM_CORES-1:0]                core_idle,
  input  logic [NUM_CORES-1:0]                core_error,
  output logic                                tick,
  output logic [TICK_COUNT_WIDTH-1:0]         tick_index,
  output logic                                running,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          error_cause,
  output logic [idx_width(NUM_CORES)-1:0]     error_core
);

  localparam int TW = TICK_COUNT_WIDTH;
  localparam int CW = idx_width(NUM_CORES);
  localparam int PW = $clog2(MIN_TICK_PERIOD) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(MIN_TICK_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

  if (MIN_TICK_PERIOD < 1 || SETTLE_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_bad_params
    $error("tick_sequencer: MIN_TICK_PERIOD, SETTLE_CYCLES and WATCHDOG_CYCLES must be >= 1");
  end

  tick_state_e   state_q;
  logic [TW-1:0] num_ticks_q;
  logic [TW-1:0] tick_index_q;
  logic [PW-1:0] period_q;
  logic [SW-1:0] settle_q;
  logic          stop_pend_q;
  logic          tick_q;
  logic          running_q;
  logic          done_q;
  logic          error_q;
  logic [1:0]    cause_q;
  logic [CW-1:0] err_core_q;

  logic [CW-1:0] err_idx;
  logic          err_valid;
  logic [TW-1:0] tick_index_d;
  logic [PW-1:0] period_d;
  logic [SW-1:0] settle_d;
  logic          period_ready;
  logic          settle_done;
  logic          finish_now;
  logic          active;
  logic          wd_expire;

  lowest_set_index #(
    .WIDTH (NUM_CORES)
  ) u_err_enc (
    .vec_i   (core_error),
    .idx_o   (err_idx),
    .valid_o (err_valid)
  );

  // Next-value helpers for the counters and the end-of-run decision.
  always_comb begin
    tick_index_d = (tick_index_q == {TW{1'b1}}) ? tick_index_q : tick_index_q + TW'(1);
    period_ready = (period_q >= PERIOD_LAST);
    period_d     = period_ready ? period_q : period_q + PW'(1);
    settle_d     = (&core_idle) ? settle_q + SW'(1) : {SW{1'b0}};
    settle_done  = (&core_idle) && (settle_d == SETTLE_LAST);
    finish_now   = stop_pend_q | stop |
                   ((num_ticks_q != {TW{1'b0}}) && (tick_index_q == num_ticks_q));
    active       = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);
  end

`ifdef TICK_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES) + 1;
  logic [WW-1:0] wd_q;
  logic [WW-1:0] wd_d;

  assign wd_d      = wd_q + WW'(1);
  assign wd_expire = ((state_q == WAIT) || (state_q == DRAIN)) && (wd_d == WW'(WATCHDOG_CYCLES));

  // Per-tick timeout: restarts on every tick, runs while waiting on the grid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= {WW{1'b0}};
    end else if (state_q == ISSUE) begin
      wd_q <= {WW{1'b0}};
    end else if ((state_q == WAIT) || (state_q == DRAIN)) begin
      wd_q <= wd_d;
    end else begin
      wd_q <= wd_q;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      num_ticks_q  <= {TW{1'b0}};
      tick_index_q <= {TW{1'b0}};
      period_q     <= {PW{1'b0}};
      settle_q     <= {SW{1'b0}};
      stop_pend_q  <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      err_core_q   <= {CW{1'b0}};
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (active && stop) begin
        stop_pend_q <= 1'b1;
      end
      if (active && (err_valid || wd_expire)) begin
        // A core error outranks both the watchdog and a completing settle.
        state_q    <= HALT;
        running_q  <= 1'b0;
        error_q    <= 1'b1;
        cause_q    <= err_valid ? CAUSE_CORE : CAUSE_WATCHDOG;
        err_core_q <= err_valid ? err_idx : {CW{1'b0}};
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              num_ticks_q  <= num_ticks;
              tick_index_q <= TW'(1);
              error_q      <= 1'b0;
              cause_q      <= CAUSE_NONE;
              err_core_q   <= {CW{1'b0}};
              stop_pend_q  <= 1'b0;
              tick_q       <= 1'b1;
              running_q    <= 1'b1;
              state_q      <= ISSUE;
            end else begin
              running_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          ISSUE: begin
            period_q <= {PW{1'b0}};
            state_q  <= WAIT;
          end
          WAIT: begin
            if (period_ready && !(|core_busy)) begin
              settle_q <= {SW{1'b0}};
              state_q  <= DRAIN;
            end else begin
              period_q <= period_d;
            end
          end
          DRAIN: begin
            if (settle_done) begin
              settle_q <= {SW{1'b0}};
              if (finish_now) begin
                done_q      <= 1'b1;
                running_q   <= 1'b0;
                stop_pend_q <= 1'b0;
                state_q     <= IDLE;
              end else begin
                tick_q       <= 1'b1;
                tick_index_q <= tick_index_d;
                state_q      <= ISSUE;
              end
            end else begin
              settle_q <= settle_d;
            end
          end
          HALT: begin
            if (start) begin
              error_q     <= 1'b0;
              cause_q     <= CAUSE_NONE;
              err_core_q  <= {CW{1'b0}};
              stop_pend_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              state_q <= HALT;
            end
          end
          default: begin
            running_q <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign tick        = tick_q;
  assign tick_index  = tick_index_q;
  assign running     = running_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_cause = cause_q;
  assign error_core  = err_core_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed and random runs checked every cycle against a timeline model.
module tb_tick_sequencer;

  localparam int NC   = 4;
  localparam int TW   = 3;
  localparam int MINP = 8;
  localparam int SET  = 2;
  localparam int N    = 700;
  localparam int RUNS = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [TW-1:0] num_ticks = '0;
  logic [NC-1:0] core_busy = '0;
  logic [NC-1:0] core_idle = '1;
  logic [NC-1:0] core_error = '0;
  logic          tick, running, done, error;
  logic [TW-1:0] tick_index;
  logic [1:0]    error_cause;
  logic [1:0]    error_core;
  logic [10:0]   obs;

  tick_sequencer #(
    .NUM_CORES        (NC),
    .TICK_COUNT_WIDTH (TW),
    .MIN_TICK_PERIOD  (MINP),
    .SETTLE_CYCLES    (SET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_ticks   (num_ticks),
    .stop        (stop),
    .core_busy   (core_busy),
    .core_idle   (core_idle),
    .core_error  (core_error),
    .tick        (tick),
    .tick_index  (tick_index),
    .running     (running),
    .done        (done),
    .error       (error),
    .error_cause (error_cause),
    .error_core  (error_core)
  );

  always #5 clk = ~clk;

  assign obs = {tick, tick_index, running, done, error, error_cause, error_core};

  int errors = 0;
  int checks = 0;

  logic [NC-1:0] s_busy [N];
  logic [NC-1:0] s_idle [N];
  logic [NC-1:0] s_err  [N];
  logic          s_start[N];
  logic          s_stop [N];
  logic [10:0]   exp_v  [N];
  int            run_end;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [10:0] pk(input logic t, input logic [TW-1:0] i, input logic r,
                                     input logic d, input logic er, input logic [1:0] c,
                                     input logic [1:0] k);
    return {t, i, r, d, er, c, k};
  endfunction

  function automatic logic [1:0] lowest(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Walks the run tick by tick: find the first non-busy edge after the minimum period,
  // then the first edge closing SET consecutive idle edges; errors and stops in between decide the ending.
  task automatic build_expect(input logic [TW-1:0] nt);
    int t0, k, w, s, h, cnt, last_e;
    logic stop_seen;
    logic [TW-1:0] idx;
    logic [10:0] run_v;
    t0 = 0;
    k = 1;
    run_end = N - 1;
    forever begin
      idx = (k >= 7) ? TW'(7) : TW'(k);
      run_v = pk(1'b0, idx, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      w = -1;
      for (int e = t0 + MINP + 1; e < N; e++) if (s_busy[e] == '0) begin w = e; break; end
      s = -1;
      if (w >= 0) begin
        cnt = 0;
        for (int e = w + 1; e < N; e++) begin
          cnt = (&s_idle[e]) ? cnt + 1 : 0;
          if (cnt == SET) begin s = e; break; end
        end
      end
      last_e = (s >= 0) ? s : N - 1;
      h = -1;
      for (int e = t0 + 1; e <= last_e; e++) if (s_err[e] != '0) begin h = e; break; end
      exp_v[t0] = pk(1'b1, idx, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      if (h >= 0) begin
        for (int e = t0 + 1; e < h; e++) exp_v[e] = run_v;
        for (int e = h; e < N; e++) begin
          exp_v[e] = pk(1'b0, idx, 1'b0, 1'b0, 1'b1, 2'b01, lowest(s_err[h]));
          if (e > h) s_start[e] = 1'b0;
        end
        if (h + 3 < N) begin
          s_start[h + 3] = 1'b1;
          for (int e = h + 3; e < N; e++) exp_v[e] = pk(1'b0, idx, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        end
        run_end = h + 3;
        return;
      end
      if (s < 0) begin
        for (int e = t0 + 1; e < N; e++) exp_v[e] = run_v;
        return;
      end
      for (int e = t0 + 1; e < s; e++) exp_v[e] = run_v;
      stop_seen = 1'b0;
      for (int e = t0 + 1; e <= s; e++) if (s_stop[e]) stop_seen = 1'b1;
      if (stop_seen || (nt != '0 && idx == nt)) begin
        exp_v[s] = pk(1'b0, idx, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        for (int e = s + 1; e < N; e++) begin
          exp_v[e]   = pk(1'b0, idx, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
          s_start[e] = 1'b0;
        end
        run_end = s;
        return;
      end
      t0 = s;
      k++;
    end
  endtask

  initial begin
    logic [TW-1:0] nt;
    int mode, last;
    repeat (2) @(posedge clk);
    #1 check_eq("reset_init", {21'd0, obs}, 32'd0);
    @(negedge clk) rst = 1'b1;
    for (int r = 0; r < RUNS; r++) begin
      for (int e = 0; e < N; e++) begin
        s_busy[e] = '0; s_idle[e] = '1; s_err[e] = '0; s_stop[e] = 1'b0; s_start[e] = 1'b0;
      end
      s_start[0] = 1'b1;
      case (r)
        0: nt = 3'd3;
        1: begin nt = 3'd3; for (int e = 1; e <= 24; e++) s_busy[e] = 4'b0010; end
        2: begin nt = 3'd2; s_idle[11] = 4'b1110; end
        3: begin nt = 3'd5; s_err[5] = 4'b0110; end
        4: begin nt = 3'd0; s_stop[25] = 1'b1; end
        5: begin nt = 3'd0; s_stop[105] = 1'b1; end
        6: begin nt = 3'd2; s_stop[0] = 1'b1; end
        default: begin
          nt = TW'($urandom_range(0, 7));
          mode = $urandom_range(0, 2);
          for (int e = 1; e < N; e++) begin
            if (mode == 1 && $urandom_range(0, 2) == 0) s_busy[e] = 4'($urandom);
            if (mode == 2 && (e % 40) >= 15 && (e % 40) < 30) s_busy[e] = 4'b1000;
            if ($urandom_range(0, 5) == 0) s_idle[e] = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) s_start[e] = 1'b1;
          end
          if ($urandom_range(0, 3) == 0) s_err[$urandom_range(1, 300)] = 4'($urandom_range(1, 15));
          if (nt == '0 || $urandom_range(0, 2) == 0) s_stop[$urandom_range(1, 150)] = 1'b1;
        end
      endcase
      build_expect(nt);
      num_ticks = nt;
      last = (run_end + 4 < N) ? run_end + 4 : N - 1;
      if (r >= 7 && $urandom_range(0, 3) == 0) last = $urandom_range(5, last);
      for (int e = 0; e <= last; e++) begin
        start      = s_start[e];
        stop       = s_stop[e];
        core_busy  = s_busy[e];
        core_idle  = s_idle[e];
        core_error = s_err[e];
        @(posedge clk);
        #1 check_eq($sformatf("run%0d_cyc%0d", r, e), {21'd0, obs}, {21'd0, exp_v[e]});
      end
      #2 rst = 1'b0;
      #1 check_eq($sformatf("reset_run%0d", r), {21'd0, obs}, 32'd0);
      @(negedge clk) rst = 1'b1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
